// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
// Shares the VGA adapter's single pixel-write port among N_REQ drawing
// engines. A requester that wins arbitration keeps the port for its whole
// burst (until it presents a pixel with 'last'), so sprite/erase sequences
// are never interleaved. A granted requester that stalls for STALL_MAX
// cycles loses its grant and sees a one-cycle abort pulse.
//
// Build option: define ARB_FIXED_PRIO_EN to select lowest-index-wins
// arbitration at burst boundaries instead of round-robin.
module vga_write_arbiter #(
  parameter int N_REQ     = 3,
  parameter int NX        = 10,
  parameter int NY        = 9,
  parameter int CD        = 9,
  parameter int STALL_MAX = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      last,
  input  logic [N_REQ*NX-1:0]   req_x,
  input  logic [N_REQ*NY-1:0]   req_y,
  input  logic [N_REQ*CD-1:0]   req_color,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      abort,
  output logic [NX-1:0]         vga_x,
  output logic [NY-1:0]         vga_y,
  output logic [CD-1:0]         vga_color,
  output logic                  vga_write
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(STALL_MAX + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
  localparam logic [SW-1:0]    STALL_TOP = SW'(STALL_MAX - 1);

  logic [0:0]    r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_gidx;
  logic [SW-1:0] r_stall_cnt;

  logic [IW-1:0] w_win_idx;
  logic          w_win_found;
  logic [IW:0]   w_cand;
  logic          w_accept;
  logic          w_stall;
  logic          w_timeout;

  // Pick the IDLE winner: first set req bit after rr_ptr (or lowest index in fixed mode).
  always_comb begin
    w_win_idx   = '0;
    w_win_found = 1'b0;
    w_cand      = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_win_idx   = IW'(k);
        w_win_found = 1'b1;
      end else begin
        w_win_idx   = w_win_idx;
      end
    end
`else
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(N_REQ)) begin
        w_cand = w_cand - (IW+1)'(N_REQ);
      end else begin
        w_cand = w_cand;
      end
      if (!w_win_found && req[w_cand[IW-1:0]]) begin
        w_win_idx   = w_cand[IW-1:0];
        w_win_found = 1'b1;
      end else begin
        w_win_idx   = w_win_idx;
      end
    end
`endif
  end

  // Burst-phase qualifiers for the currently granted requester.
  always_comb begin
    w_accept  = (r_state == ST_BURST) && req[r_gidx] && gnt[r_gidx];
    w_stall   = (r_state == ST_BURST) && !req[r_gidx];
    w_timeout = w_stall && (r_stall_cnt == STALL_TOP);
  end

  // Arbitration FSM, stall watchdog and registered pixel-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= IW'(N_REQ - 1);
      r_gidx      <= '0;
      r_stall_cnt <= '0;
      gnt         <= '0;
      abort       <= '0;
      vga_write   <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_color   <= '0;
    end else begin
      abort     <= '0;
      vga_write <= w_accept;
      if (w_accept) begin
        vga_x     <= req_x[r_gidx*NX +: NX];
        vga_y     <= req_y[r_gidx*NY +: NY];
        vga_color <= req_color[r_gidx*CD +: CD];
      end
      case (r_state)
        ST_IDLE: begin
          r_stall_cnt <= '0;
          if (w_win_found) begin
            gnt     <= ONE_HOT0 << w_win_idx;
            r_gidx  <= w_win_idx;
            r_state <= ST_BURST;
          end else begin
            gnt <= '0;
          end
        end
        ST_BURST: begin
          if (w_accept) begin
            r_stall_cnt <= '0;
            if (last[r_gidx]) begin
              gnt      <= '0;
              r_rr_ptr <= r_gidx;
              r_state  <= ST_IDLE;
            end
          end else if (w_timeout) begin
            // Watchdog expired: revoke the grant and tell the requester.
            abort       <= gnt;
            gnt         <= '0;
            r_rr_ptr    <= r_gidx;
            r_stall_cnt <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
          end
        end
        default: begin
          gnt     <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
